// File: rtl/hps_reset_arbiter.sv
// Purpose: fixed-priority arbiter turning FPGA-side cold/warm/debug reset requests into HPS f2h request pulses.
// Latency: 2 clk from a request rising edge to the matching *_req_n going low (1 to pend, 1 to grant).
// Backpressure: none; requests pend while busy or while hps_up is low, with repeats merged and counted.
//
// Ports:
//   clk, reset      - 50 MHz clock, synchronous active-high reset
//   src_req         - level requests, source i on bits [3i+2:3i] = {debug, warm, cold}
//   hps_up          - HPS out of reset; gates every grant
//   cold/warm/debug_req_n - active-low request pulses to the HPS
//   busy            - high in ASSERT and HOLDOFF
//   active_type     - 0 none, 1 cold, 2 warm, 3 debug
//   pending         - {debug, warm, cold} pending flags
//   merge_cnt       - saturating count of requests folded into an existing pending flag
module hps_reset_arbiter #(
   parameter int NUM_SRC     = 2,
   parameter int COLD_PULSE  = 6,
   parameter int WARM_PULSE  = 2,
   parameter int DEBUG_PULSE = 32,
   parameter int HOLDOFF     = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3*NUM_SRC-1:0] src_req,
   input  logic                 hps_up,
   output logic                 cold_req_n,
   output logic                 warm_req_n,
   output logic                 debug_req_n,
   output logic                 busy,
   output logic [1:0]           active_type,
   output logic [2:0]           pending,
   output logic [7:0]           merge_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLDOFF} state_t;

   state_t               state_q, state_d;
   logic [7:0]           pulse_q, pulse_d;
   logic [15:0]          hold_q, hold_d;
   logic [1:0]           type_d;
   logic [2:0]           clr;
   logic [3*NUM_SRC-1:0] hist_q;
   logic [3*NUM_SRC-1:0] rise;
   logic [7:0]           rise_cnt [3];
   logic [2:0]           edge_any;
   logic [9:0]           merge_add;
   logic [9:0]           merge_sum;
   logic [7:0]           merge_nxt;

   // Edge detect and merge accounting. A flag that is being cleared by a
   // grant this cycle does not absorb an edge: the first edge re-pends it.
   always_comb begin
      rise      = src_req & ~hist_q;
      edge_any  = '0;
      merge_add = '0;
      for (int t = 0; t < 3; t++) begin
         rise_cnt[t] = '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            rise_cnt[t] = rise_cnt[t] + 8'(rise[3*i+t]);
         end
         edge_any[t] = (rise_cnt[t] != 8'd0);
         if (pending[t] && !clr[t]) begin
            merge_add = merge_add + 10'(rise_cnt[t]);
         end else if (rise_cnt[t] != 8'd0) begin
            merge_add = merge_add + 10'(rise_cnt[t] - 8'd1);
         end
      end
      merge_sum = {2'b00, merge_cnt} + merge_add;
      merge_nxt = (merge_sum > 10'd255) ? 8'hff : merge_sum[7:0];
   end

   always_comb begin
      state_d = state_q;
      pulse_d = pulse_q;
      hold_d  = hold_q;
      type_d  = active_type;
      clr     = '0;
      case (state_q)
         S_IDLE: begin
            type_d = 2'd0;
            if (hps_up && (pending != 3'b000)) begin
               state_d = S_ASSERT;
               if (pending[0]) begin
                  clr     = 3'b001;
                  type_d  = 2'd1;
                  pulse_d = 8'(COLD_PULSE);
               end else if (pending[1]) begin
                  clr     = 3'b010;
                  type_d  = 2'd2;
                  pulse_d = 8'(WARM_PULSE);
               end else begin
                  clr     = 3'b100;
                  type_d  = 2'd3;
                  pulse_d = 8'(DEBUG_PULSE);
               end
            end
         end
         S_ASSERT: begin
            // Cold takes over a running warm/debug pulse with no gap; the
            // preempted request counts as served.
            if (hps_up && pending[0] && (active_type != 2'd1)) begin
               clr     = 3'b001;
               type_d  = 2'd1;
               pulse_d = 8'(COLD_PULSE);
            end else if (pulse_q == 8'd1) begin
               type_d = 2'd0;
               if (HOLDOFF == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_HOLDOFF;
                  hold_d  = 16'(HOLDOFF);
               end
            end else begin
               pulse_d = pulse_q - 8'd1;
            end
         end
         S_HOLDOFF: begin
            type_d = 2'd0;
            if (hold_q == 16'd1) begin
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            type_d  = 2'd0;
         end
      endcase
   end

   // Outputs are registered from next-state values so req_n tracks the
   // FSM without any combinational path from src_req.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pulse_q     <= '0;
         hold_q      <= '0;
         active_type <= 2'd0;
         cold_req_n  <= 1'b1;
         warm_req_n  <= 1'b1;
         debug_req_n <= 1'b1;
         busy        <= 1'b0;
         pending     <= '0;
         merge_cnt   <= '0;
         hist_q      <= '1;
      end else begin
         state_q     <= state_d;
         pulse_q     <= pulse_d;
         hold_q      <= hold_d;
         active_type <= type_d;
         cold_req_n  <= (type_d != 2'd1);
         warm_req_n  <= (type_d != 2'd2);
         debug_req_n <= (type_d != 2'd3);
         busy        <= (state_d != S_IDLE);
         pending     <= (pending & ~clr) | edge_any;
         merge_cnt   <= merge_nxt;
         hist_q      <= src_req;
      end
   end

endmodule

// File: tb/tb_hps_reset_arbiter.sv
// Purpose: directed bench for hps_reset_arbiter (default parameters).
// Latency: inputs change and outputs are compared on the falling edge of each cycle.
// Backpressure: not applicable; every wait is a fixed cycle span.
module tb_hps_reset_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] src_req;
   logic       hps_up;
   logic       cold_req_n, warm_req_n, debug_req_n, busy;
   logic [1:0] active_type;
   logic [2:0] pending;
   logic [7:0] merge_cnt;

   int checks = 0;
   int passes = 0;

   hps_reset_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .src_req     (src_req),
      .hps_up      (hps_up),
      .cold_req_n  (cold_req_n),
      .warm_req_n  (warm_req_n),
      .debug_req_n (debug_req_n),
      .busy        (busy),
      .active_type (active_type),
      .pending     (pending),
      .merge_cnt   (merge_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [5:0] src;
      logic       up;
      logic [2:0] e_req;   // {debug, warm, cold}
      logic       e_busy;
      logic [1:0] e_at;
      logic [2:0] e_pend;
      logic [7:0] e_mc;
   } vec_t;

   vec_t vecs [13];

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [16:0] pack_exp(input logic [2:0] r, input logic b, input logic [1:0] a,
                                            input logic [2:0] p, input logic [7:0] m);
      return {r, b, a, p, m};
   endfunction

   function automatic logic [16:0] pack_act();
      return {debug_req_n, warm_req_n, cold_req_n, busy, active_type, pending, merge_cnt};
   endfunction

   task automatic chk_state(input string nm, input logic [2:0] r, input logic b, input logic [1:0] a,
                            input logic [2:0] p, input logic [7:0] m);
      logic [16:0] act, exp;
      act = pack_act();
      exp = pack_exp(r, b, a, p, m);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got req_n(d,w,c)=%b busy=%b type=%0d pend=%b merge=%0d, want req_n=%b busy=%b type=%0d pend=%b merge=%0d",
                    nm, act[16:14], act[13], act[12:11], act[10:8], act[7:0], r, b, a, p, m);
   endtask

   // Holds the current inputs for n cycles and expects the same outputs in each.
   task automatic run_span(input string nm, input int n, input logic [2:0] r, input logic b,
                           input logic [1:0] a, input logic [2:0] p, input logic [7:0] m);
      int bad;
      logic [16:0] act, exp, last_bad;
      bad      = 0;
      last_bad = '0;
      exp      = pack_exp(r, b, a, p, m);
      for (int k = 0; k < n; k++) begin
         cyc();
         act = pack_act();
         if (act !== exp) begin
            bad++;
            last_bad = act;
         end
      end
      checks++;
      if (bad == 0) passes++;
      else $display("FAIL %s: %0d of %0d cycles wrong, last got {req_n,busy,type,pend,merge}=%b, want %b",
                    nm, bad, n, last_bad, exp);
   endtask

   initial begin
      // Quiet after reset (src0 cold held high through reset), then a single cold.
      vecs[0]  = '{1'b0, 6'b000001, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0};
      vecs[1]  = '{1'b0, 6'b000001, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0};
      vecs[2]  = '{1'b0, 6'b000001, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0};
      vecs[3]  = '{1'b0, 6'b000000, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0};
      vecs[4]  = '{1'b0, 6'b000001, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0}; // T
      vecs[5]  = '{1'b0, 6'b000001, 1'b1, 3'b111, 1'b0, 2'd0, 3'b001, 8'd0}; // T+1
      vecs[6]  = '{1'b0, 6'b000001, 1'b1, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0}; // T+2
      vecs[7]  = '{1'b0, 6'b000001, 1'b1, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0};
      vecs[8]  = '{1'b0, 6'b000001, 1'b1, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0};
      vecs[9]  = '{1'b0, 6'b000001, 1'b1, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0};
      vecs[10] = '{1'b0, 6'b000001, 1'b1, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0};
      vecs[11] = '{1'b0, 6'b000001, 1'b1, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0}; // T+7
      vecs[12] = '{1'b0, 6'b000001, 1'b1, 3'b111, 1'b1, 2'd0, 3'b000, 8'd0}; // T+8 holdoff

      reset   = 1'b1;
      src_req = 6'b000001;
      hps_up  = 1'b1;
      repeat (3) cyc();
      chk_state("reset_state", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);

      for (int i = 0; i < 13; i++) begin
         cyc();
         reset   = vecs[i].rst;
         src_req = vecs[i].src;
         hps_up  = vecs[i].up;
         chk_state($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_busy, vecs[i].e_at,
                   vecs[i].e_pend, vecs[i].e_mc);
      end
      run_span("cold_holdoff", 999, 3'b111, 1'b1, 2'd0, 3'b000, 8'd0);
      cyc(); chk_state("cold_idle", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);

      // Merge with hps_up low, then one warm pulse once released.
      cyc(); src_req = 6'b000000; hps_up = 1'b0;
      chk_state("merge_idle", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);
      cyc(); src_req = 6'b010010;
      chk_state("merge_idle2", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);
      cyc(); src_req = 6'b010000;
      chk_state("merge_first", 3'b111, 1'b0, 2'd0, 3'b010, 8'd1);
      cyc(); src_req = 6'b010010;
      chk_state("merge_first2", 3'b111, 1'b0, 2'd0, 3'b010, 8'd1);
      cyc(); chk_state("merge_two", 3'b111, 1'b0, 2'd0, 3'b010, 8'd2);
      run_span("gated_no_grant", 10, 3'b111, 1'b0, 2'd0, 3'b010, 8'd2);
      cyc(); hps_up = 1'b1;
      chk_state("gated_release", 3'b111, 1'b0, 2'd0, 3'b010, 8'd2);
      run_span("warm_pulse", 2, 3'b101, 1'b1, 2'd2, 3'b000, 8'd2);
      cyc(); chk_state("warm_done", 3'b111, 1'b1, 2'd0, 3'b000, 8'd2);
      run_span("warm_holdoff", 999, 3'b111, 1'b1, 2'd0, 3'b000, 8'd2);
      cyc(); chk_state("warm_idle", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      run_span("warm_once", 10, 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);

      // Priority: warm and debug in the same cycle.
      cyc(); src_req = 6'b000000;
      chk_state("prio_idle", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      cyc(); src_req = 6'b000110;
      chk_state("prio_idle2", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      cyc(); chk_state("prio_both_pend", 3'b111, 1'b0, 2'd0, 3'b110, 8'd2);
      run_span("prio_warm_first", 2, 3'b101, 1'b1, 2'd2, 3'b100, 8'd2);
      cyc(); chk_state("prio_warm_done", 3'b111, 1'b1, 2'd0, 3'b100, 8'd2);
      run_span("prio_holdoff", 999, 3'b111, 1'b1, 2'd0, 3'b100, 8'd2);
      cyc(); chk_state("prio_debug_waits", 3'b111, 1'b0, 2'd0, 3'b100, 8'd2);
      run_span("prio_debug_pulse", 32, 3'b011, 1'b1, 2'd3, 3'b000, 8'd2);
      cyc(); chk_state("prio_debug_done", 3'b111, 1'b1, 2'd0, 3'b000, 8'd2);
      run_span("prio_debug_holdoff", 999, 3'b111, 1'b1, 2'd0, 3'b000, 8'd2);
      cyc(); chk_state("prio_idle_end", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);

      // Cold preempts a debug pulse at its 10th low cycle.
      cyc(); src_req = 6'b000000;
      chk_state("pre_idle", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      cyc(); src_req = 6'b000100;
      chk_state("pre_idle2", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      cyc(); chk_state("pre_debug_pend", 3'b111, 1'b0, 2'd0, 3'b100, 8'd2);
      run_span("pre_debug_low", 9, 3'b011, 1'b1, 2'd3, 3'b000, 8'd2);
      cyc(); src_req = 6'b000101;
      chk_state("pre_debug_10th", 3'b011, 1'b1, 2'd3, 3'b000, 8'd2);
      cyc(); chk_state("pre_cold_pend", 3'b011, 1'b1, 2'd3, 3'b001, 8'd2);
      run_span("pre_cold_pulse", 6, 3'b110, 1'b1, 2'd1, 3'b000, 8'd2);
      cyc(); chk_state("pre_cold_done", 3'b111, 1'b1, 2'd0, 3'b000, 8'd2);
      run_span("pre_holdoff", 999, 3'b111, 1'b1, 2'd0, 3'b000, 8'd2);
      cyc(); chk_state("pre_idle_end", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      run_span("pre_no_debug_repeat", 20, 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);

      // Reset during the 3rd cycle of a cold pulse.
      cyc(); src_req = 6'b000100;
      chk_state("rst_idle", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      cyc(); src_req = 6'b000101;
      chk_state("rst_idle2", 3'b111, 1'b0, 2'd0, 3'b000, 8'd2);
      cyc(); chk_state("rst_cold_pend", 3'b111, 1'b0, 2'd0, 3'b001, 8'd2);
      cyc(); chk_state("rst_cold_1", 3'b110, 1'b1, 2'd1, 3'b000, 8'd2);
      cyc(); chk_state("rst_cold_2", 3'b110, 1'b1, 2'd1, 3'b000, 8'd2);
      cyc(); chk_state("rst_cold_3", 3'b110, 1'b1, 2'd1, 3'b000, 8'd2);
      reset = 1'b1;
      cyc(); reset = 1'b0;
      chk_state("rst_mid_pulse", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);
      run_span("rst_no_resume", 10, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);
      cyc(); src_req = 6'b000100;
      chk_state("rst_quiet", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);
      cyc(); src_req = 6'b000101;
      chk_state("rst_quiet2", 3'b111, 1'b0, 2'd0, 3'b000, 8'd0);
      cyc(); chk_state("rst_new_pend", 3'b111, 1'b0, 2'd0, 3'b001, 8'd0);
      cyc(); chk_state("rst_new_pulse", 3'b110, 1'b1, 2'd1, 3'b000, 8'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
